// File: rtl/timer_multi_pkg.sv
// Shared constants and types for the multi-channel APB timer.
package timer_multi_pkg;

    // Per-channel register offsets
    localparam logic [2:0] OFF_TDR  = 3'd0;
    localparam logic [2:0] OFF_TCR  = 3'd1;
    localparam logic [2:0] OFF_TSR  = 3'd2;
    localparam logic [2:0] OFF_TIER = 3'd3;
    localparam logic [2:0] OFF_TCNT = 3'd4;

    // TCR bit positions
    localparam int unsigned TCR_LOAD = 7;
    localparam int unsigned TCR_ARLD = 6;
    localparam int unsigned TCR_DN   = 5;
    localparam int unsigned TCR_EN   = 4;
    localparam int unsigned CKS_MAX_BITS = 4;

    // TSR / TIER bit positions
    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

    // TCR layout, MSB first; cks is masked to PSC_BITS inside the channel
    typedef struct packed {
        logic       load;
        logic       arld;
        logic       dn;
        logic       en;
        logic [3:0] cks;
    } tcr_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: registers, prescaler, up/down counter, sticky flags, irq.
module timer_channel
    import timer_multi_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned PSC_BITS  = 3
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 wr_tdr,
    input  logic                 wr_tcr,
    input  logic                 wr_tsr,
    input  logic                 wr_tier,
    input  logic [CNT_WIDTH-1:0] wdata,
    input  logic [2:0]           rd_off,
    output logic [CNT_WIDTH-1:0] rdata_c,
    output logic                 irq_c
);

    localparam int unsigned PSC_W    = 1 << PSC_BITS;
    localparam logic [3:0]  CKS_MASK = 4'((1 << PSC_BITS) - 1);

    logic [CNT_WIDTH-1:0] tdr;
    logic [CNT_WIDTH-1:0] tcnt;
    tcr_t                 tcr;
    logic [7:0]           tcr_raw;
    logic [1:0]           tsr;
    logic [1:0]           tier;
    logic [PSC_W-1:0]     psc;
    logic [PSC_W-1:0]     psc_mask;
    logic                 run;
    logic                 tick;
    logic                 set_ovf;
    logic                 set_udf;
    logic [1:0]           clr;

    assign tcr_raw = tcr;
    assign run     = tcr.en & ~tcr.load;

    // Tick when the low cks+1 prescaler bits are all ones
    always_comb begin
        psc_mask = '0;
        for (int i = 0; i < int'(PSC_W); i++) begin
            psc_mask[i] = (i <= int'(tcr.cks));
        end
    end

    assign tick    = run & ((psc & psc_mask) == psc_mask);
    assign set_ovf = tick & ~tcr.dn & (&tcnt);
    assign set_udf = tick &  tcr.dn & (tcnt == '0);
    assign clr     = wr_tsr ? wdata[1:0] : 2'b00;

    // Configuration registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tdr  <= '0;
            tcr  <= '0;
            tier <= '0;
        end else begin
            if (wr_tdr) tdr <= wdata;
            if (wr_tcr) begin
                tcr.load <= wdata[TCR_LOAD];
                tcr.arld <= wdata[TCR_ARLD];
                tcr.dn   <= wdata[TCR_DN];
                tcr.en   <= wdata[TCR_EN];
                tcr.cks  <= wdata[CKS_MAX_BITS-1:0] & CKS_MASK;
            end
            if (wr_tier) tier <= wdata[1:0];
        end
    end

    // Free-running prescaler, held at zero while stopped or loading
    always_ff @(posedge pclk or posedge preset) begin
        if (preset)       psc <= '0;
        else if (run)     psc <= psc + PSC_W'(1);
        else              psc <= '0;
    end

    // Counter: load has priority, otherwise step on tick with wrap/reload
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tcnt <= '0;
        end else if (tcr.load) begin
            tcnt <= tdr;
        end else if (tick) begin
            if (set_ovf)      tcnt <= tcr.arld ? tdr : '0;
            else if (set_udf) tcnt <= tcr.arld ? tdr : '1;
            else if (tcr.dn)  tcnt <= tcnt - CNT_WIDTH'(1);
            else              tcnt <= tcnt + CNT_WIDTH'(1);
        end
    end

    // Sticky flags; a hardware set beats a simultaneous W1C
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) tsr <= '0;
        else        tsr <= (tsr & ~clr) | {set_udf, set_ovf};
    end

    // Register read view
    always_comb begin
        rdata_c = '0;
        case (rd_off)
            OFF_TDR:  rdata_c = tdr;
            OFF_TCR:  rdata_c = CNT_WIDTH'(tcr_raw);
            OFF_TSR:  rdata_c = CNT_WIDTH'(tsr);
            OFF_TIER: rdata_c = CNT_WIDTH'(tier);
            OFF_TCNT: rdata_c = tcnt;
            default:  rdata_c = '0;
        endcase
    end

    assign irq_c = |(tsr & tier);

endmodule

// File: rtl/timer_multi_ch.sv
// APB front end: address decode, error response, read mux and channel array.
module timer_multi_ch
    import timer_multi_pkg::*;
#(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned PSC_BITS  = 3,
    parameter int unsigned CH_BITS   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [CH_BITS+2:0]   paddr,
    input  logic [CNT_WIDTH-1:0] pwdata,
    output logic [CNT_WIDTH-1:0] prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [CH_NUM-1:0]    tmr_irq
);

    logic [CH_BITS-1:0]   ch;
    logic [2:0]           off;
    logic                 access;
    logic                 ch_valid;
    logic                 addr_ok;
    logic                 wr_ok;
    logic [CNT_WIDTH-1:0] ch_rdata [CH_NUM];

    assign ch     = paddr[CH_BITS+2:3];
    assign off    = paddr[2:0];
    assign access = psel & penable;
    assign pready = 1'b1;

    // Channel index check by enumeration so any CH_NUM works
    always_comb begin
        ch_valid = 1'b0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (ch == CH_BITS'(i)) ch_valid = 1'b1;
        end
    end

    assign addr_ok = ch_valid & (off <= OFF_TCNT);
    assign wr_ok   = access & pwrite & addr_ok & ~preset;
    assign pslverr = access & ~addr_ok & ~preset;

    // Read mux, zero outside a valid read access phase
    always_comb begin
        prdata = '0;
        if (access & ~pwrite & addr_ok & ~preset) begin
            for (int i = 0; i < int'(CH_NUM); i++) begin
                if (ch == CH_BITS'(i)) prdata = ch_rdata[i];
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic sel;
        assign sel = wr_ok & (ch == CH_BITS'(g));

        timer_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .PSC_BITS  (PSC_BITS)
        ) u_ch (
            .pclk    (pclk),
            .preset  (preset),
            .wr_tdr  (sel & (off == OFF_TDR)),
            .wr_tcr  (sel & (off == OFF_TCR)),
            .wr_tsr  (sel & (off == OFF_TSR)),
            .wr_tier (sel & (off == OFF_TIER)),
            .wdata   (pwdata),
            .rd_off  (off),
            .rdata_c (ch_rdata[g]),
            .irq_c   (tmr_irq[g])
        );
    end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Directed self-checking bench for timer_multi_ch.
module tb_timer_multi_ch;

    localparam int unsigned AW  = 5;
    localparam int unsigned AW5 = 6;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [15:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [3:0]  tmr_irq;

    logic        p5_sel, p5_enable, p5_write;
    logic [AW5-1:0] p5_addr;
    logic [15:0] p5_wdata, p5_rdata;
    logic        p5_ready, p5_slverr;
    logic [4:0]  p5_irq;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    timer_multi_ch #(.CH_NUM(4), .CNT_WIDTH(16), .PSC_BITS(3)) u_dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .tmr_irq(tmr_irq)
    );

    timer_multi_ch #(.CH_NUM(5), .CNT_WIDTH(16), .PSC_BITS(3)) u_dut5 (
        .pclk(pclk), .preset(preset), .psel(p5_sel), .penable(p5_enable),
        .pwrite(p5_write), .paddr(p5_addr), .pwdata(p5_wdata), .prdata(p5_rdata),
        .pready(p5_ready), .pslverr(p5_slverr), .tmr_irq(p5_irq)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // APB write; call just after a posedge, returns 1ns after the commit edge
    task automatic apb_write(input int ch, input int off, input logic [15:0] data, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = AW'(ch * 8 + off); pwdata = data;
        @(posedge pclk); #1 penable = 1'b1;
        #1 err = pslverr;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // APB read; data sampled in the access phase
    task automatic apb_read(input int ch, input int off, output logic [15:0] data, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = AW'(ch * 8 + off);
        @(posedge pclk); #1 penable = 1'b1;
        #1 data = prdata; err = pslverr;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge pclk); #1;
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        logic err;
        preset = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        paddr = AW'(7); pwdata = '0;
        p5_sel = 1'b0; p5_enable = 1'b0; p5_write = 1'b0; p5_addr = '0; p5_wdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b want 0", pslverr); end
        checks++; if (prdata !== 16'h0) begin errors++; $display("FAIL rst_prdata: got %h want 0", prdata); end
        checks++; if (tmr_irq !== 4'h0) begin errors++; $display("FAIL rst_irq: got %b want 0", tmr_irq); end
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL pready: got %b want 1", pready); end
        psel = 1'b0; penable = 1'b0; preset = 1'b0;
        @(posedge pclk); #1;
        for (int c = 0; c < 4; c++) begin
            for (int o = 0; o < 5; o++) begin
                apb_read(c, o, rd, err);
                checks++; if (rd !== 16'h0) begin errors++; $display("FAIL rst_val ch%0d off%0d: got %h want 0", c, o, rd); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err ch%0d off%0d: got %b want 0", c, o, err); end
            end
        end
        for (int o = 5; o < 8; o++) begin
            apb_read(0, o, rd, err);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_off_err off%0d: got %b want 1", o, err); end
            checks++; if (rd !== 16'h0) begin errors++; $display("FAIL bad_off_rd off%0d: got %h want 0", o, rd); end
        end
        apb_write(0, 5, 16'hFFFF, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_wr_err: got %b want 1", err); end
        apb_read(0, 0, rd, err);
        checks++; if (rd !== 16'h0) begin errors++; $display("FAIL bad_wr_effect: tdr got %h want 0", rd); end
        // channel 5 on a 5-channel instance is out of range, channel 4 is not
        p5_sel = 1'b1; p5_addr = AW5'(5 * 8);
        @(posedge pclk); #1 p5_enable = 1'b1;
        #1;
        checks++; if (p5_slverr !== 1'b1) begin errors++; $display("FAIL ch5_err: got %b want 1", p5_slverr); end
        checks++; if (p5_rdata !== 16'h0) begin errors++; $display("FAIL ch5_rd: got %h want 0", p5_rdata); end
        @(posedge pclk); #1 p5_enable = 1'b0; p5_addr = AW5'(4 * 8);
        @(posedge pclk); #1 p5_enable = 1'b1;
        #1;
        checks++; if (p5_slverr !== 1'b0) begin errors++; $display("FAIL ch4_err: got %b want 0", p5_slverr); end
        checks++; if (p5_irq !== 5'h0) begin errors++; $display("FAIL ch5_irq: got %b want 0", p5_irq); end
        checks++; if (p5_ready !== 1'b1) begin errors++; $display("FAIL ch5_ready: got %b want 1", p5_ready); end
        @(posedge pclk); #1 p5_sel = 1'b0; p5_enable = 1'b0;
    endtask

    task automatic test_down_underflow();
        logic [15:0] rd;
        logic err;
        int t0;
        apb_write(2, 3, 16'h0002, err);
        apb_write(2, 0, 16'h0005, err);
        apb_write(2, 1, 16'h0080, err);
        apb_write(2, 1, 16'h0033, err);
        t0 = cyc;
        wait_to(t0 + 95);
        checks++; if (tmr_irq[2] !== 1'b0) begin errors++; $display("FAIL udf_early: got %b want 0", tmr_irq[2]); end
        wait_to(t0 + 96);
        checks++; if (tmr_irq[2] !== 1'b1) begin errors++; $display("FAIL udf_96: got %b want 1", tmr_irq[2]); end
        apb_read(2, 2, rd, err);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL udf_tsr: got %h want 0002", rd); end
        apb_read(2, 4, rd, err);
        checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL udf_tcnt: got %h want ffff", rd); end
        apb_read(2, 1, rd, err);
        checks++; if (rd !== 16'h0033) begin errors++; $display("FAIL tcr_rd: got %h want 0033", rd); end
    endtask

    task automatic test_arld();
        logic [15:0] rd;
        logic err;
        int t0;
        apb_write(2, 1, 16'h0080, err);
        apb_write(2, 2, 16'h0003, err);
        apb_write(2, 1, 16'h0073, err);
        t0 = cyc;
        wait_to(t0 + 95);
        checks++; if (tmr_irq[2] !== 1'b0) begin errors++; $display("FAIL arld_early: got %b want 0", tmr_irq[2]); end
        wait_to(t0 + 96);
        checks++; if (tmr_irq[2] !== 1'b1) begin errors++; $display("FAIL arld_96: got %b want 1", tmr_irq[2]); end
        apb_read(2, 4, rd, err);
        checks++; if (rd !== 16'h0005) begin errors++; $display("FAIL arld_tcnt: got %h want 0005", rd); end
        apb_write(2, 2, 16'h0002, err);
        checks++; if (tmr_irq[2] !== 1'b0) begin errors++; $display("FAIL arld_clr: got %b want 0", tmr_irq[2]); end
        wait_to(t0 + 191);
        checks++; if (tmr_irq[2] !== 1'b0) begin errors++; $display("FAIL arld2_early: got %b want 0", tmr_irq[2]); end
        wait_to(t0 + 192);
        checks++; if (tmr_irq[2] !== 1'b1) begin errors++; $display("FAIL arld2_192: got %b want 1", tmr_irq[2]); end
    endtask

    task automatic test_w1c_collision();
        logic [15:0] rd;
        logic err;
        int t0;
        apb_write(2, 1, 16'h0080, err);
        apb_write(2, 2, 16'h0003, err);
        apb_write(2, 1, 16'h0033, err);
        t0 = cyc;
        wait_to(t0 + 94);
        apb_write(2, 2, 16'h0002, err);
        checks++; if (tmr_irq[2] !== 1'b1) begin errors++; $display("FAIL w1c_collide: got %b want 1", tmr_irq[2]); end
        apb_read(2, 2, rd, err);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL w1c_collide_tsr: got %h want 0002", rd); end
        apb_write(2, 2, 16'h0000, err);
        checks++; if (tmr_irq[2] !== 1'b1) begin errors++; $display("FAIL w0_noeffect: got %b want 1", tmr_irq[2]); end
        apb_write(2, 2, 16'h0002, err);
        checks++; if (tmr_irq[2] !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b want 0", tmr_irq[2]); end
        apb_read(2, 2, rd, err);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL w1c_clear_tsr: got %h want 0000", rd); end
    endtask

    task automatic test_up_overflow();
        logic [15:0] rd;
        logic err;
        int t0;
        apb_write(0, 3, 16'h0001, err);
        apb_write(0, 0, 16'hFFFE, err);
        apb_write(0, 1, 16'h0080, err);
        apb_write(0, 1, 16'h0010, err);
        t0 = cyc;
        wait_to(t0 + 3);
        checks++; if (tmr_irq[0] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", tmr_irq[0]); end
        wait_to(t0 + 4);
        checks++; if (tmr_irq[0] !== 1'b1) begin errors++; $display("FAIL ovf_4: got %b want 1", tmr_irq[0]); end
        apb_read(0, 4, rd, err);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL ovf_tcnt: got %h want 0000", rd); end
        apb_read(0, 2, rd, err);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL ovf_tsr: got %h want 0001", rd); end
    endtask

    task automatic test_independence();
        logic [15:0] rd;
        logic err;
        int ta, tb;
        apb_write(0, 0, 16'hFFFD, err);
        apb_write(0, 1, 16'h0080, err);
        apb_write(0, 2, 16'h0003, err);
        apb_write(0, 3, 16'h0003, err);
        apb_write(1, 0, 16'h0002, err);
        apb_write(1, 1, 16'h0080, err);
        apb_write(1, 3, 16'h0003, err);
        apb_write(0, 1, 16'h0010, err);
        ta = cyc;
        apb_write(1, 1, 16'h0033, err);
        tb = cyc;
        wait_to(ta + 5);
        checks++; if (tmr_irq[0] !== 1'b0) begin errors++; $display("FAIL ind_ch0_early: got %b want 0", tmr_irq[0]); end
        wait_to(ta + 6);
        checks++; if (tmr_irq[0] !== 1'b1) begin errors++; $display("FAIL ind_ch0_ovf: got %b want 1", tmr_irq[0]); end
        checks++; if (tmr_irq[1] !== 1'b0) begin errors++; $display("FAIL ind_ch1_cross: got %b want 0", tmr_irq[1]); end
        checks++; if (tmr_irq[3] !== 1'b0) begin errors++; $display("FAIL ind_ch3: got %b want 0", tmr_irq[3]); end
        wait_to(tb + 47);
        checks++; if (tmr_irq[1] !== 1'b0) begin errors++; $display("FAIL ind_ch1_early: got %b want 0", tmr_irq[1]); end
        wait_to(tb + 48);
        checks++; if (tmr_irq[1] !== 1'b1) begin errors++; $display("FAIL ind_ch1_udf: got %b want 1", tmr_irq[1]); end
        apb_write(1, 4, 16'h1234, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tcnt_wr_err: got %b want 0", err); end
        apb_read(1, 4, rd, err);
        checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL tcnt_wr_ignored: got %h want ffff", rd); end
        apb_read(0, 2, rd, err);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL ind_tsr0: got %h want 0001", rd); end
        apb_read(1, 2, rd, err);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL ind_tsr1: got %h want 0002", rd); end
    endtask

    task automatic test_reset_midcount();
        logic [15:0] rd;
        logic err;
        int t0;
        apb_write(1, 2, 16'h0003, err);
        apb_write(1, 0, 16'h0005, err);
        apb_write(1, 1, 16'h0080, err);
        apb_write(1, 1, 16'h0033, err);
        t0 = cyc;
        wait_to(t0 + 40);
        apb_read(1, 4, rd, err);
        checks++; if (rd !== 16'h0003) begin errors++; $display("FAIL mid_tcnt: got %h want 0003", rd); end
        checks++; if (tmr_irq[0] !== 1'b1) begin errors++; $display("FAIL mid_irq_pre: got %b want 1", tmr_irq[0]); end
        #2 preset = 1'b1;
        #1;
        checks++; if (tmr_irq !== 4'h0) begin errors++; $display("FAIL mid_irq_async: got %b want 0", tmr_irq); end
        @(posedge pclk); #1 preset = 1'b0;
        apb_read(1, 4, rd, err);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_tcnt_rst: got %h want 0", rd); end
        apb_read(1, 1, rd, err);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_tcr_rst: got %h want 0", rd); end
        apb_read(0, 2, rd, err);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_tsr_rst: got %h want 0", rd); end
        apb_read(0, 3, rd, err);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_tier_rst: got %h want 0", rd); end
        repeat (40) @(posedge pclk);
        #1;
        apb_read(1, 4, rd, err);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_no_tick: got %h want 0", rd); end
        apb_read(2, 4, rd, err);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_no_tick2: got %h want 0", rd); end
        checks++; if (tmr_irq !== 4'h0) begin errors++; $display("FAIL mid_irq_after: got %b want 0", tmr_irq); end
    endtask

    initial begin
        test_reset();
        test_down_underflow();
        test_arld();
        test_w1c_collision();
        test_up_overflow();
        test_independence();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
